// File: rtl/delay_trigger_ctrl.sv
// delay_trigger_ctrl
// Upstream control stage for the delay timer. The raw trigger is synchronised
// and debounced. Its rising edge launches the timer once the controller is
// armed. The controller then tracks the timer's done level, optionally
// re-launches the timer for a programmed number of runs, and reports
// completion and a run count.
//
// Optional build macro: DELAY_TRIG_CLR_TIMEOUT_EN
//   defined   : WAIT_CLR is supervised by a cycle counter. If timer_done
//               stays high for CLR_TIMEOUT cycles, err is set (sticky until
//               reset or the next arm) and the controller drops to IDLE.
//   undefined : err is tied low and WAIT_CLR waits indefinitely.
module delay_trigger_ctrl #(
    parameter int DEB_CYCLES  = 16,
    parameter int CNT_W       = 8,
    parameter int CLR_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_in,
    input  logic             arm,
    input  logic             abort,
    input  logic             repeat_en,
    input  logic [CNT_W-1:0] repeat_target,
    input  logic             timer_done,
    output logic             start,
    output logic             busy,
    output logic             complete,
    output logic [CNT_W-1:0] run_count,
    output logic             err
);

    // Debounce counter only needs to reach DEB_CYCLES-1.
    localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // Reject parameter sets the debounce and watchdog cannot honour.
    if (DEB_CYCLES < 2 || CLR_TIMEOUT < 1) begin : g_param_check
        $error("delay_trigger_ctrl: DEB_CYCLES must be >= 2 and CLR_TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_LAUNCH   = 3'd2,
        ST_WAIT_CLR = 3'd3,
        ST_RUN      = 3'd4,
        ST_FINISH   = 3'd5
    } state_e;

    // Saturating increment: the run counter never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Trigger path
    // ------------------------------------------------------------------
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_lvl_q;
    logic             deb_lvl_d;
    logic             deb_prev_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;
    logic             trig_evt_s;

    // Two-flop synchroniser for the asynchronous trigger input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= trig_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive samples that disagree with the accepted level.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        deb_lvl_d = deb_lvl_q;
        if (sync2_q == deb_lvl_q) begin
            deb_cnt_d = {DEB_W{1'b0}};
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_lvl_d = sync2_q;
            deb_cnt_d = {DEB_W{1'b0}};
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
    end

    // Debounce state and the previous level used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q  <= {DEB_W{1'b0}};
            deb_lvl_q  <= 1'b0;
            deb_prev_q <= 1'b0;
        end else begin
            deb_cnt_q  <= deb_cnt_d;
            deb_lvl_q  <= deb_lvl_d;
            deb_prev_q <= deb_lvl_q;
        end
    end

    assign trig_evt_s = deb_lvl_q & ~deb_prev_q;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] tgt_q;
    logic [CNT_W-1:0] tgt_d;
    logic [CNT_W-1:0] run_cnt_q;
    logic [CNT_W-1:0] run_cnt_d;
    logic [CNT_W-1:0] run_inc_s;
    logic             start_q;
    logic             busy_q;
    logic             complete_q;

`ifdef DELAY_TRIG_CLR_TIMEOUT_EN
    localparam int CLR_W = (CLR_TIMEOUT > 1) ? $clog2(CLR_TIMEOUT) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_TIMEOUT - 1);
    logic [CLR_W-1:0] clr_cnt_q;
    logic [CLR_W-1:0] clr_cnt_d;
    logic             err_q;
    logic             err_d;
`endif

    assign run_inc_s = sat_inc(run_cnt_q);

    // Next-state logic; abort overrides every state and freezes the run count.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        run_cnt_d = run_cnt_q;
`ifdef DELAY_TRIG_CLR_TIMEOUT_EN
        clr_cnt_d = clr_cnt_q;
        err_d     = err_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d   = ST_ARMED;
                        run_cnt_d = {CNT_W{1'b0}};
`ifdef DELAY_TRIG_CLR_TIMEOUT_EN
                        err_d     = 1'b0;
`endif
                        // A zero target in repeat mode still means one run.
                        if (repeat_en && (repeat_target == {CNT_W{1'b0}})) begin
                            tgt_d = CNT_W'(1);
                        end else begin
                            tgt_d = repeat_target;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (trig_evt_s) begin
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_LAUNCH: begin
                    state_d = ST_WAIT_CLR;
`ifdef DELAY_TRIG_CLR_TIMEOUT_EN
                    clr_cnt_d = {CLR_W{1'b0}};
`endif
                end
                ST_WAIT_CLR: begin
                    // A done level left over from the previous run must clear first.
                    if (!timer_done) begin
                        state_d = ST_RUN;
`ifdef DELAY_TRIG_CLR_TIMEOUT_EN
                    end else if (clr_cnt_q == CLR_LAST) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + CLR_W'(1);
`endif
                    end else begin
                        state_d = ST_WAIT_CLR;
                    end
                end
                ST_RUN: begin
                    if (timer_done) begin
                        run_cnt_d = run_inc_s;
                        if (repeat_en && (run_inc_s < tgt_q)) begin
                            state_d = ST_LAUNCH;
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, target and run-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tgt_q     <= {CNT_W{1'b0}};
            run_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    // Outputs are registered decodes of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            start_q    <= (state_d == ST_LAUNCH);
            busy_q     <= (state_d != ST_IDLE);
            complete_q <= (state_d == ST_FINISH);
        end
    end

`ifdef DELAY_TRIG_CLR_TIMEOUT_EN
    // Clear-timeout watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q <= {CLR_W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign start     = start_q;
    assign busy      = busy_q;
    assign complete  = complete_q;
    assign run_count = run_cnt_q;

endmodule

// File: tb/tb_delay_trigger_ctrl.sv
// Bench for delay_trigger_ctrl: a behavioural model (trigger history window
// plus a run-sequence tracker) is compared against the DUT every cycle, and
// directed scenarios pin latency, pulse counts and run counts to literals.
`timescale 1ns/1ps
module tb_delay_trigger_ctrl;

    localparam int DEB    = 4;
    localparam int CW     = 8;
    localparam int CLR_TO = 4;

    localparam int M_IDLE = 0, M_ARMED = 1, M_LAUNCH = 2, M_WAIT = 3, M_RUN = 4, M_FINISH = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trig_in = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          repeat_en = 1'b0;
    logic [CW-1:0] repeat_target = '0;
    logic          timer_done = 1'b0;
    logic          start;
    logic          busy;
    logic          complete;
    logic [CW-1:0] run_count;
    logic          err;

    always #5 clk = ~clk;

    delay_trigger_ctrl #(
        .DEB_CYCLES  (DEB),
        .CNT_W       (CW),
        .CLR_TIMEOUT (CLR_TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .trig_in       (trig_in),
        .arm           (arm),
        .abort         (abort),
        .repeat_en     (repeat_en),
        .repeat_target (repeat_target),
        .timer_done    (timer_done),
        .start         (start),
        .busy          (busy),
        .complete      (complete),
        .run_count     (run_count),
        .err           (err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_start = 0;
    int n_comp = 0;

    // behavioural model state
    int m_mode;
    int m_tgt;
    int m_cnt;
    int m_wait;
    bit m_err;
    bit m_lvl;
    bit m_lvl_prev;
    bit hist[$];

    // simple delay-timer model: done falls on start, rises 10 cycles later
    bit tmr_auto = 1'b1;
    int tcnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_tgt = 0; m_cnt = 0; m_wait = 0; m_err = 1'b0;
        m_lvl = 1'b0; m_lvl_prev = 1'b0;
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
    endtask

    // One clock of the model: the trigger level is accepted once the DEB
    // samples seen two cycles ago agree; the sequence advances by the rules.
    task automatic model_step();
        bit evt;
        bit same;
        int nm;
        evt = m_lvl && !m_lvl_prev;
        nm = m_mode;
        if (abort) begin
            nm = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (arm) begin
                    nm = M_ARMED;
                    m_tgt = (repeat_en && repeat_target == 0) ? 1 : int'(repeat_target);
                    m_cnt = 0;
                    m_err = 1'b0;
                end
                M_ARMED: if (evt) nm = M_LAUNCH;
                M_LAUNCH: begin nm = M_WAIT; m_wait = 0; end
                M_WAIT: begin
                    if (!timer_done) nm = M_RUN;
`ifdef DELAY_TRIG_CLR_TIMEOUT_EN
                    else begin
                        m_wait++;
                        if (m_wait >= CLR_TO) begin m_err = 1'b1; nm = M_IDLE; end
                    end
`endif
                end
                M_RUN: if (timer_done) begin
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                    nm = (repeat_en && m_cnt < m_tgt) ? M_LAUNCH : M_FINISH;
                end
                M_FINISH: nm = M_IDLE;
                default: nm = M_IDLE;
            endcase
        end
        m_mode = nm;
        hist.push_back(trig_in);
        void'(hist.pop_front());
        m_lvl_prev = m_lvl;
        same = 1'b1;
        for (int i = 1; i < DEB; i++) if (hist[i] != hist[0]) same = 1'b0;
        if (same) m_lvl = hist[0];
    endtask

    // Advance one cycle: update model at the edge, compare #1 later,
    // then drive the timer model on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        #1;
        cyc++;
        check("start", start, (m_mode == M_LAUNCH));
        check("busy", busy, (m_mode != M_IDLE));
        check("complete", complete, (m_mode == M_FINISH));
        check("run_count", run_count, m_cnt);
        check("err", err, m_err);
        n_start += int'(start);
        n_comp  += int'(complete);
        @(negedge clk);
        if (tmr_auto) begin
            if (start) begin
                timer_done = 1'b0;
                tcnt = 10;
            end else if (tcnt > 0) begin
                tcnt--;
                if (tcnt == 0) timer_done = 1'b1;
            end
        end
    endtask

    task automatic wait_start(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = start;
        end
        check("start_within_budget", seen, 1);
    endtask

    // Settle trigger low, arm, raise trigger and wait for the launch.
    task automatic fire(input logic ren, input logic [CW-1:0] tg, output int lat);
        int t0;
        trig_in = 1'b0;
        repeat (8) tick();
        repeat_en = ren;
        repeat_target = tg;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("busy_after_arm", busy, 1);
        trig_in = 1'b1;
        t0 = cyc;
        wait_start(15);
        lat = cyc - t0;
    endtask

    initial begin
        int lat;
        int s0;
        int c0;
        model_reset();

        // reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_run_count", run_count, 0);
        rst_n = 1'b1;

        // single run, latency 2 sync + 4 debounce + 1 edge
        s0 = n_start; c0 = n_comp;
        fire(1'b0, 8'd0, lat);
        check("t1_latency", lat, 7);
        repeat (20) tick();
        check("t1_starts", n_start - s0, 1);
        check("t1_completes", n_comp - c0, 1);
        check("t1_run_count", run_count, 1);

        // bouncing trigger
        trig_in = 1'b0;
        repeat (8) tick();
        s0 = n_start; c0 = n_comp;
        repeat_en = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            trig_in = ((i / 2) % 2 == 0);
            tick();
        end
        check("t2_no_start_bounce", n_start - s0, 0);
        trig_in = 1'b1;
        repeat (30) tick();
        check("t2_starts", n_start - s0, 1);
        check("t2_completes", n_comp - c0, 1);

        // repeat mode, three runs; a stray arm mid-sequence is ignored
        s0 = n_start; c0 = n_comp;
        fire(1'b1, 8'd3, lat);
        repeat_target = 8'd5;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (45) tick();
        check("t3_starts", n_start - s0, 3);
        check("t3_completes", n_comp - c0, 1);
        check("t3_run_count", run_count, 3);

        // stale done level before arm is not counted
        tmr_auto = 1'b0;
        timer_done = 1'b1;
        s0 = n_start; c0 = n_comp;
        fire(1'b0, 8'd0, lat);
        repeat (2) tick();
        timer_done = 1'b0;
        repeat (9) tick();
        check("t4_count_before_done", run_count, 0);
        timer_done = 1'b1;
        repeat (4) tick();
        check("t4_run_count", run_count, 1);
        check("t4_completes", n_comp - c0, 1);
        check("t4_starts", n_start - s0, 1);
        timer_done = 1'b0;
        tcnt = 0;
        tmr_auto = 1'b1;

        // abort during the second run of a repeat sequence
        s0 = n_start; c0 = n_comp;
        fire(1'b1, 8'd3, lat);
        wait_start(15);
        repeat (3) tick();
        check("t5_count_pre_abort", run_count, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_run_count", run_count, 1);
        repeat (15) tick();
        check("t5_completes", n_comp - c0, 0);
        check("t5_starts", n_start - s0, 2);

        // asynchronous reset in the middle of a run
        fire(1'b1, 8'd2, lat);
        wait_start(15);
        repeat (3) tick();
        check("t6_count_pre_rst", run_count, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_start", start, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_complete", complete, 0);
        check("t6_rst_run_count", run_count, 0);
        check("t6_rst_err", err, 0);
        tick();
        rst_n = 1'b1;
        repeat (15) tick();

        // timer_done stuck high after launch
        tmr_auto = 1'b0;
        timer_done = 1'b1;
        c0 = n_comp;
        fire(1'b0, 8'd0, lat);
        repeat (8) tick();
`ifdef DELAY_TRIG_CLR_TIMEOUT_EN
        check("t7_err", err, 1);
        check("t7_busy", busy, 0);
`else
        check("t7_err", err, 0);
        check("t7_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif
        check("t7_completes", n_comp - c0, 0);
        timer_done = 1'b0;
        tcnt = 0;
        tmr_auto = 1'b1;

        // repeat mode with zero target behaves as a single run
        s0 = n_start; c0 = n_comp;
        fire(1'b1, 8'd0, lat);
        repeat (20) tick();
        check("t8_starts", n_start - s0, 1);
        check("t8_run_count", run_count, 1);
        check("t8_completes", n_comp - c0, 1);
        check("t8_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/delay_trigger_ctrl.md
Name: delay_trigger_ctrl

Overview:
Upstream control stage for the delay timer. It debounces an external trigger, arms on command, and issues a one-cycle start pulse to the timer. It then tracks the timer's done level and optionally re-launches the timer a programmed number of times. It reports completion and a run count to the system.

Parameters:
DEB_CYCLES, 16, consecutive stable cycles required before the synchronised trigger level is accepted (minimum 2)
CNT_W, 8, width of the repeat target and run counter
CLR_TIMEOUT, 4, maximum cycles allowed for timer_done to fall after start (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
trig_in  input  1  raw external trigger, asynchronous to clk
arm  input  1  one-cycle pulse; arms the controller from IDLE
abort  input  1  level; forces return to IDLE
repeat_en  input  1  1 = re-launch the timer until repeat_target runs have completed
repeat_target  input  CNT_W  number of runs in repeat mode; sampled on arm
timer_done  input  1  done level from the delay timer
start  output  1  one-cycle start pulse to the delay timer
busy  output  1  high in every state except IDLE
complete  output  1  one-cycle pulse when the sequence finishes
run_count  output  CNT_W  completed runs in the current or last sequence
err  output  1  sticky timeout flag (optional feature)

Behaviour:
- Reset (async assert, sync release): state=IDLE; start=0, busy=0, complete=0, run_count=0, err=0; synchroniser and debounce state cleared to level 0.
- Trigger path: 2-flop synchroniser, then debounce counter. The debounced level changes only after DEB_CYCLES consecutive equal synchronised samples. Rising-edge detect on the debounced level yields trig_evt (one cycle).
- Latency: a clean 0->1 on trig_in produces trig_evt at most 2+DEB_CYCLES+1 cycles later.
- FSM states: IDLE, ARMED, LAUNCH, WAIT_CLR, RUN, FINISH.
- IDLE: arm=1 -> ARMED. The same cycle latches repeat_target into tgt and clears run_count to 0. If repeat_en=1 and repeat_target=0, tgt is forced to 1.
- ARMED: trig_evt -> LAUNCH. Triggers are ignored in all other states; no queueing.
- LAUNCH: start=1 for exactly this cycle -> WAIT_CLR.
- WAIT_CLR: stays until timer_done=0, then -> RUN. A stale done=1 from a previous run must not be counted.
- RUN: on timer_done=1, run_count increments.
  - If repeat_en=1 and the incremented count < tgt -> LAUNCH.
  - Otherwise -> FINISH.
- FINISH: complete=1 for this cycle -> IDLE.
- run_count holds its value in IDLE until the next arm. Increments saturate at all-ones and never wrap.
- abort=1 has priority in every state: next state is IDLE, no start is issued that cycle, run_count is held, and complete is not pulsed.
- arm while not in IDLE is ignored. repeat_en is sampled live in RUN.
- Back-to-back repeat runs: timer_done=1 in RUN to start=1 is 1 cycle (RUN->LAUNCH).
- busy is a registered decode of state!=IDLE.

Optional Feature:
Macro DELAY_TRIG_CLR_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT_CLR. If timer_done is still 1 after CLR_TIMEOUT cycles in WAIT_CLR, err is set (sticky until reset or the next arm) and the FSM goes to IDLE without pulsing complete.
- Not defined: the err port exists but is tied to 0, and WAIT_CLR waits indefinitely.

Test Plan:
- DEB_CYCLES=4: arm pulse, then trig_in 0->1 held -> exactly one start pulse 7 cycles (±1) after the edge; busy=1 from the cycle after arm.
- Bounce: trig_in toggles every 2 cycles for 20 cycles, then settles at 1 -> no start until 4 stable cycles have passed; exactly one start overall.
- repeat_en=1, repeat_target=3, timer model raises done 10 cycles after each start -> three start pulses, each 1 cycle after done; complete once; run_count=3.
- timer_done held at 1 before arm: start issued, done drops 2 cycles later, done rises after 10 cycles -> run_count=1 and the stale done is not counted.
- abort asserted in RUN -> IDLE next cycle, busy=0, complete stays 0, run_count unchanged. rst_n pulsed low mid-RUN -> all outputs 0 immediately.
- With DELAY_TRIG_CLR_TIMEOUT_EN, CLR_TIMEOUT=4 and timer_done stuck at 1 -> err=1 after 4 cycles in WAIT_CLR, FSM returns to IDLE, no complete. Without the macro -> err stays 0 and busy stays 1.
